draw_circles_multi: RTL and testbench

Parametrised multi-object circle draw stage for the VGA pixel pipeline; the successor to the single-circle and single-ball draw stages.
- Takes the timing/rgb bundle from the previous stage and overlays N_OBJ filled circles, each with its own colour, radius and position.
- Object positions are sampled once per frame at vertical blanking, so sprites never tear mid-frame.
- Fixed 3-cycle pipeline; all timing signals are delayed to stay aligned with rgb_out.

---
 rtl/draw_circles_multi.sv | 151 +++++++++++++++
 tb/tb_draw_circles_multi.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/draw_circles_multi.sv
// Multi-object circle overlay stage for the VGA pixel pipeline: N_OBJ circles, 3-cycle latency.
// Define DRAW_CIRCLES_OUTLINE_EN to draw 2-pixel rings instead of filled discs.
module draw_circles_multi #(
    parameter int                  N_OBJ       = 2,
    parameter logic [12*N_OBJ-1:0] COLORS      = {12'h0_0_b, 12'hf_0_0},
    parameter logic [8*N_OBJ-1:0]  RADII       = {8'd20, 8'd20},
    parameter logic [11:0]         BLANK_COLOR = 12'h0_0_0
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [11:0]           hcount_in,
    input  logic [11:0]           vcount_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  hblnk_in,
    input  logic                  vblnk_in,
    input  logic [11:0]           rgb_in,
    input  logic [12*N_OBJ-1:0]   xpos_in,
    input  logic [12*N_OBJ-1:0]   ypos_in,
    input  logic [N_OBJ-1:0]      obj_en,
    output logic [11:0]           hcount_out,
    output logic [11:0]           vcount_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  hblnk_out,
    output logic                  vblnk_out,
    output logic [11:0]           rgb_out,
    output logic [N_OBJ-1:0]      hit_mask,
    output logic [12*N_OBJ-1:0]   xpos_out,
    output logic [12*N_OBJ-1:0]   ypos_out
);

    // Timing bundle layout: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    localparam int TW = 40;

    logic [TW-1:0]         tm_in;
    logic [TW-1:0]         tm1_q, tm2_q;
    logic [TW-13:0]        tm3_q;
    logic                  vblnk_d_q;
    logic                  frame_latch;
    logic [12*N_OBJ-1:0]   xpos_sh_q, ypos_sh_q;
    logic [N_OBJ-1:0]      en_sh_q;
    logic signed [12:0]    dx_d [N_OBJ];
    logic signed [12:0]    dy_d [N_OBJ];
    logic signed [12:0]    dx_q [N_OBJ];
    logic signed [12:0]    dy_q [N_OBJ];
    logic [N_OBJ-1:0]      en1_q;
    logic [N_OBJ-1:0]      hit_d, hit2_q;
    logic [11:0]           rgb_d, rgb_q;
    logic [N_OBJ-1:0]      mask_d, mask_q;

    assign tm_in       = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
    assign frame_latch = vblnk_in & ~vblnk_d_q;

    // Positions are only taken at the start of vertical blanking so a frame never tears
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            vblnk_d_q <= 1'b0;
            xpos_sh_q <= '0;
            ypos_sh_q <= '0;
            en_sh_q   <= '0;
        end else begin
            vblnk_d_q <= vblnk_in;
            if (frame_latch) begin
                xpos_sh_q <= xpos_in;
                ypos_sh_q <= ypos_in;
                en_sh_q   <= obj_en;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_OBJ; i++) begin
            dx_d[i] = $signed({1'b0, hcount_in}) - $signed({1'b0, xpos_sh_q[12*i +: 12]});
            dy_d[i] = $signed({1'b0, vcount_in}) - $signed({1'b0, ypos_sh_q[12*i +: 12]});
        end
    end

    for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
        localparam logic [7:0]  R   = RADII[8*g +: 8];
        localparam logic [15:0] RSQ = 16'(R) * 16'(R);
        logic signed [25:0] sqx, sqy;
        logic [25:0]        d2;

        assign sqx = dx_q[g] * dx_q[g];
        assign sqy = dy_q[g] * dy_q[g];
        assign d2  = $unsigned(sqx) + $unsigned(sqy);
`ifdef DRAW_CIRCLES_OUTLINE_EN
        // Radii below 2 have no inner hole, so they fall back to a filled disc
        localparam bit          RING   = (R >= 8'd2);
        localparam logic [7:0]  RIN    = RING ? (R - 8'd2) : 8'd0;
        localparam logic [15:0] RIN_SQ = 16'(RIN) * 16'(RIN);
        assign hit_d[g] = en1_q[g] && (R != 8'd0) && (d2 <= {10'd0, RSQ})
                          && (!RING || (d2 > {10'd0, RIN_SQ}));
`else
        assign hit_d[g] = en1_q[g] && (R != 8'd0) && (d2 <= {10'd0, RSQ});
`endif
    end

    always_comb begin
        rgb_d  = tm2_q[11:0];
        mask_d = hit2_q;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (hit2_q[i]) rgb_d = COLORS[12*i +: 12];
        end
        if (tm2_q[13] || tm2_q[12]) begin
            rgb_d  = BLANK_COLOR;
            mask_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            tm1_q  <= '0;
            tm2_q  <= '0;
            tm3_q  <= '0;
            en1_q  <= '0;
            hit2_q <= '0;
            rgb_q  <= '0;
            mask_q <= '0;
            for (int i = 0; i < N_OBJ; i++) begin
                dx_q[i] <= '0;
                dy_q[i] <= '0;
            end
        end else begin
            tm1_q  <= tm_in;
            tm2_q  <= tm1_q;
            tm3_q  <= tm2_q[TW-1:12];
            en1_q  <= en_sh_q;
            hit2_q <= hit_d;
            rgb_q  <= rgb_d;
            mask_q <= mask_d;
            for (int i = 0; i < N_OBJ; i++) begin
                dx_q[i] <= dx_d[i];
                dy_q[i] <= dy_d[i];
            end
        end
    end

    assign hcount_out = tm3_q[27:16];
    assign vcount_out = tm3_q[15:4];
    assign hsync_out  = tm3_q[3];
    assign vsync_out  = tm3_q[2];
    assign hblnk_out  = tm3_q[1];
    assign vblnk_out  = tm3_q[0];
    assign rgb_out    = rgb_q;
    assign hit_mask   = mask_q;
    assign xpos_out   = xpos_sh_q;
    assign ypos_out   = ypos_sh_q;

endmodule

// File: tb/tb_draw_circles_multi.sv
// Directed bench for draw_circles_multi: pixel table plus hand sequences for latching, latency and reset.
module tb_draw_circles_multi;

    logic        clk_in = 1'b0;
    logic        rst;
    logic [11:0] hcount_in, vcount_in, rgb_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [23:0] xpos_in, ypos_in;
    logic [1:0]  obj_en;
    logic [11:0] hcount_out, vcount_out, rgb_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [1:0]  hit_mask;
    logic [23:0] xpos_out, ypos_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] h;
        logic [11:0] v;
        logic        hs;
        logic        hb;
        logic [11:0] rgb;
        logic [11:0] expRgb;
        logic [1:0]  expMask;
    } vec_t;

    vec_t vecs[7];
    logic hsSeq[32];

    // Object 0 is blue, object 1 is red; both radius 20
    draw_circles_multi #(
        .N_OBJ(2),
        .COLORS({12'hf_0_0, 12'h0_0_b}),
        .RADII({8'd20, 8'd20}),
        .BLANK_COLOR(12'h0_0_0)
    ) dut (
        .clk_in(clk_in), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos_in(xpos_in), .ypos_in(ypos_in), .obj_en(obj_en),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .hit_mask(hit_mask),
        .xpos_out(xpos_out), .ypos_out(ypos_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] h, input logic [11:0] v, input logic hs,
                                 input logic hb, input logic [11:0] rgb);
        @(negedge clk_in);
        hcount_in = h;
        vcount_in = v;
        hsync_in  = hs;
        hblnk_in  = hb;
        rgb_in    = rgb;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk_in);
        #1;
    endtask

    task automatic doVblankEdge();
        @(negedge clk_in);
        vblnk_in = 1'b0;
        @(negedge clk_in);
        vblnk_in = 1'b1;
        @(negedge clk_in);
        vblnk_in = 1'b0;
    endtask

    task automatic checkPixel(input string name, input logic [11:0] h, input logic [11:0] v,
                              input logic [11:0] rgb, input logic [11:0] expRgb,
                              input logic [1:0] expMask);
        applyStimulus(h, v, 1'b0, 1'b0, rgb);
        settle();
        checkOutput({name, "_rgb"}, 32'(rgb_out), 32'(expRgb));
        checkOutput({name, "_mask"}, 32'(hit_mask), 32'(expMask));
    endtask

    initial begin
        rst = 1'b0;
        hcount_in = '0; vcount_in = '0; rgb_in = '0;
        hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
        xpos_in = '0; ypos_in = '0; obj_en = '0;

`ifdef DRAW_CIRCLES_OUTLINE_EN
        vecs[0] = '{12'd100, 12'd100, 1'b1, 1'b0, 12'h123, 12'h123, 2'b00};
        vecs[1] = '{12'd119, 12'd100, 1'b0, 1'b0, 12'h123, 12'h00b, 2'b01};
        vecs[2] = '{12'd118, 12'd100, 1'b1, 1'b0, 12'h123, 12'h123, 2'b00};
        vecs[3] = '{12'd120, 12'd100, 1'b0, 1'b0, 12'h456, 12'h00b, 2'b01};
        vecs[4] = '{12'd121, 12'd100, 1'b1, 1'b0, 12'h456, 12'h456, 2'b00};
        vecs[5] = '{12'd80,  12'd100, 1'b0, 1'b0, 12'h789, 12'h00b, 2'b01};
        vecs[6] = '{12'd119, 12'd100, 1'b1, 1'b1, 12'h789, 12'h000, 2'b00};
`else
        vecs[0] = '{12'd100, 12'd100, 1'b1, 1'b0, 12'h123, 12'h00b, 2'b01};
        vecs[1] = '{12'd121, 12'd100, 1'b0, 1'b0, 12'h123, 12'h123, 2'b00};
        vecs[2] = '{12'd120, 12'd100, 1'b1, 1'b0, 12'h123, 12'h00b, 2'b01};
        vecs[3] = '{12'd115, 12'd115, 1'b0, 1'b0, 12'h456, 12'h456, 2'b00};
        vecs[4] = '{12'd80,  12'd100, 1'b1, 1'b0, 12'h456, 12'h00b, 2'b01};
        vecs[5] = '{12'd100, 12'd79,  1'b0, 1'b0, 12'h789, 12'h789, 2'b00};
        vecs[6] = '{12'd100, 12'd100, 1'b1, 1'b1, 12'h789, 12'h000, 2'b00};
`endif

        // Reset state
        #12;
        checkOutput("reset_rgb", 32'(rgb_out), 32'h0);
        checkOutput("reset_mask", 32'(hit_mask), 32'h0);
        checkOutput("reset_timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
        checkOutput("reset_xpos", 32'(xpos_out), 32'h0);
        checkOutput("reset_ypos", 32'(ypos_out), 32'h0);
        @(negedge clk_in);
        rst = 1'b1;

        // Positions given but not yet latched: nothing drawn
        xpos_in = {12'd100, 12'd100};
        ypos_in = {12'd100, 12'd100};
        obj_en  = 2'b01;
        checkPixel("prelatch", 12'd120, 12'd100, 12'h321, 12'h321, 2'b00);

        doVblankEdge();
        checkOutput("latch_xpos", 32'(xpos_out), 32'({12'd100, 12'd100}));
        checkOutput("latch_ypos", 32'(ypos_out), 32'({12'd100, 12'd100}));

        // Single enabled circle; obj1 sits on the same centre but is disabled
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].hb, vecs[i].rgb);
            settle();
            checkOutput($sformatf("vec%0d_rgb", i), 32'(rgb_out), 32'(vecs[i].expRgb));
            checkOutput($sformatf("vec%0d_mask", i), 32'(hit_mask), 32'(vecs[i].expMask));
            checkOutput($sformatf("vec%0d_hcount", i), 32'(hcount_out), 32'(vecs[i].h));
            checkOutput($sformatf("vec%0d_hsync", i), 32'(hsync_out), 32'(vecs[i].hs));
            checkOutput($sformatf("vec%0d_hblnk", i), 32'(hblnk_out), 32'(vecs[i].hb));
        end

        // Exact latency: background pixel, then a hit pixel appears on the 3rd edge
        applyStimulus(12'd300, 12'd300, 1'b0, 1'b0, 12'habc);
        settle();
        applyStimulus(12'd120, 12'd100, 1'b0, 1'b0, 12'h123);
        @(posedge clk_in); #1;
        checkOutput("lat_edge1", 32'(rgb_out), 32'habc);
        @(posedge clk_in); #1;
        checkOutput("lat_edge2", 32'(rgb_out), 32'habc);
        @(posedge clk_in); #1;
        checkOutput("lat_edge3", 32'(rgb_out), 32'h00b);

        // Overlap: both objects on (200,200), index 0 wins
        xpos_in = {12'd200, 12'd200};
        ypos_in = {12'd200, 12'd200};
        obj_en  = 2'b11;
        doVblankEdge();
        checkPixel("overlap", 12'd219, 12'd200, 12'h555, 12'h00b, 2'b11);
        checkPixel("overlap_out", 12'd221, 12'd200, 12'h555, 12'h555, 2'b00);

        // Mid-frame move of object 0 has no effect until the next vblank edge
        applyStimulus(12'd10, 12'd300, 1'b0, 1'b0, 12'h111);
        xpos_in = {12'd200, 12'd400};
        checkPixel("midmove_old", 12'd219, 12'd200, 12'h222, 12'h00b, 2'b11);
        checkPixel("midmove_new_pos", 12'd419, 12'd200, 12'h222, 12'h222, 2'b00);
        checkOutput("midmove_xpos", 32'(xpos_out), 32'({12'd200, 12'd200}));
        @(negedge clk_in);
        vblnk_in = 1'b1;
        checkOutput("edge_xpos_before", 32'(xpos_out), 32'({12'd200, 12'd200}));
        @(posedge clk_in); #1;
        checkOutput("edge_xpos_after", 32'(xpos_out), 32'({12'd200, 12'd400}));
        @(negedge clk_in);
        vblnk_in = 1'b0;
        checkPixel("moved_obj1", 12'd219, 12'd200, 12'h333, 12'hf00, 2'b10);
        checkPixel("moved_obj0", 12'd419, 12'd200, 12'h333, 12'h00b, 2'b01);

        // hsync follows input with fixed 3-cycle delay
        for (int k = 0; k < 32; k++) hsSeq[k] = 1'($urandom_range(0, 1));
        for (int k = 0; k < 32; k++) begin
            @(negedge clk_in);
            hsync_in = hsSeq[k];
            @(posedge clk_in); #1;
            if (k >= 2) checkOutput($sformatf("hsync_dly%0d", k), 32'(hsync_out), 32'(hsSeq[k-2]));
        end

        // Asynchronous reset mid-line
        applyStimulus(12'd419, 12'd200, 1'b1, 1'b0, 12'h444);
        settle();
        checkOutput("prereset_rgb", 32'(rgb_out), 32'h00b);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async_rgb", 32'(rgb_out), 32'h0);
        checkOutput("async_mask", 32'(hit_mask), 32'h0);
        checkOutput("async_hsync", 32'(hsync_out), 32'h0);
        checkOutput("async_hcount", 32'(hcount_out), 32'h0);
        checkOutput("async_xpos", 32'(xpos_out), 32'h0);
        @(negedge clk_in);
        rst = 1'b1;
        checkPixel("postreset", 12'd419, 12'd200, 12'h444, 12'h444, 2'b00);
        checkOutput("postreset_xpos", 32'(xpos_out), 32'h0);
        doVblankEdge();
        checkPixel("postreset_latch", 12'd419, 12'd200, 12'h444, 12'h00b, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
